// File: rtl/sram_responder.sv
// rtl/sram_responder.sv - on-chip stand-in for the external 8-bit asynchronous SRAM
// Decodes the active-low strobe pair every edge and serves reads through a READ_LAT-deep pipe.
module sram_responder #(
  parameter int ADDR_W   = 18,
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 4096,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  inout  wire  [DATA_W-1:0] sram,
  input  logic              wr_enable,
  input  logic              rd_enable,
  output logic [ADDR_W-1:0] wr_count,
  output logic [ADDR_W-1:0] rd_count,
  output logic              err_conflict,
  output logic              rd_valid
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int LAST  = READ_LAT - 1;

  logic [DATA_W-1:0] r_mem [DEPTH] = '{default: '0};
  logic [DATA_W-1:0] r_pipe_data [READ_LAT];
  logic [READ_LAT-1:0] r_pipe_valid;
  logic [ADDR_W-1:0] r_wr_count;
  logic [ADDR_W-1:0] r_rd_count;
  logic              r_err_conflict;

  logic             w_write;
  logic             w_read;
  logic             w_conflict;
  logic             w_drive;
  logic [IDX_W-1:0] w_idx;

  assign w_write    = ~wr_enable &  rd_enable;
  assign w_read     =  wr_enable & ~rd_enable;
  assign w_conflict = ~wr_enable & ~rd_enable;
  assign w_idx      = addr[IDX_W-1:0];

  // Address bits above the array index alias onto the same word.
  generate
    if (IDX_W < ADDR_W) begin : g_alias
      logic w_addr_hi_unused;
      assign w_addr_hi_unused = ^addr[ADDR_W-1:IDX_W];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pipe_valid   <= '0;
      r_wr_count     <= '0;
      r_rd_count     <= '0;
      r_err_conflict <= 1'b0;
    end else begin
      if (w_conflict) begin
        r_pipe_valid   <= '0;
        r_err_conflict <= 1'b1;
      end else begin
        r_pipe_valid[0] <= w_read;
        for (int i = 1; i < READ_LAT; i++) begin
          r_pipe_valid[i] <= r_pipe_valid[i-1];
        end
      end
      if (w_write) r_wr_count <= r_wr_count + ADDR_W'(1);
      if (w_read)  r_rd_count <= r_rd_count + ADDR_W'(1);
    end
  end

  // Read data is snapshotted at launch, so later writes cannot disturb an in-flight read.
  always_ff @(posedge clk) begin
    if (w_read) r_pipe_data[0] <= r_mem[w_idx];
    for (int i = 1; i < READ_LAT; i++) begin
      r_pipe_data[i] <= r_pipe_data[i-1];
    end
    if (w_write) r_mem[w_idx] <= sram;
  end

  // Gate on live strobes so we release the bus the moment the controller turns it around.
  assign w_drive      = r_pipe_valid[LAST] & ~rd_enable & wr_enable;
  assign sram         = w_drive ? r_pipe_data[LAST] : {DATA_W{1'bz}};
  assign rd_valid     = w_drive;
  assign wr_count     = r_wr_count;
  assign rd_count     = r_rd_count;
  assign err_conflict = r_err_conflict;

endmodule

// File: tb/tb_sram_responder.sv
// tb/tb_sram_responder.sv - directed bench for sram_responder at READ_LAT 1, 3 and 4
module tb_sram_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [17:0] addr = '0;
  logic        wr_n = 1'b1;
  logic        rd_n = 1'b1;
  logic        tb_drv = 1'b0;
  logic [7:0]  tb_data = '0;

  wire  [7:0]  bus1, bus3, bus4;
  logic [17:0] wc1, rc1, wc3, rc3, wc4, rc4;
  logic        err1, err3, err4, rv1, rv3, rv4;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign bus1 = tb_drv ? tb_data : 8'bz;
  assign bus3 = tb_drv ? tb_data : 8'bz;
  assign bus4 = tb_drv ? tb_data : 8'bz;

  sram_responder #(.ADDR_W(18), .DATA_W(8), .DEPTH(4096), .READ_LAT(1)) u_l1 (
    .clk(clk), .rst(rst), .addr(addr), .sram(bus1), .wr_enable(wr_n), .rd_enable(rd_n),
    .wr_count(wc1), .rd_count(rc1), .err_conflict(err1), .rd_valid(rv1));

  sram_responder #(.ADDR_W(18), .DATA_W(8), .DEPTH(4096), .READ_LAT(3)) u_l3 (
    .clk(clk), .rst(rst), .addr(addr), .sram(bus3), .wr_enable(wr_n), .rd_enable(rd_n),
    .wr_count(wc3), .rd_count(rc3), .err_conflict(err3), .rd_valid(rv3));

  sram_responder #(.ADDR_W(18), .DATA_W(8), .DEPTH(4096), .READ_LAT(4)) u_l4 (
    .clk(clk), .rst(rst), .addr(addr), .sram(bus4), .wr_enable(wr_n), .rd_enable(rd_n),
    .wr_count(wc4), .rd_count(rc4), .err_conflict(err4), .rd_valid(rv4));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Hold one bus cycle across a rising edge; the bench drives data whenever wr is low.
  task automatic step(input logic w, input logic r, input logic [17:0] a, input logic [7:0] d);
    wr_n    = w;
    rd_n    = r;
    addr    = a;
    tb_drv  = ~w;
    tb_data = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    step(1, 1, 18'h0, 8'h00);
    step(1, 1, 18'h0, 8'h00);
    check("rst_rv1", {31'b0, rv1}, 0);
    check("rst_wc1", {14'b0, wc1}, 0);
    check("rst_rc1", {14'b0, rc1}, 0);
    check("rst_err1", {31'b0, err1}, 0);
    rst = 1'b0;

    step(0, 1, 18'h00010, 8'hA5);
    check("wc_after_w1", {14'b0, wc1}, 1);
    step(0, 1, 18'h00011, 8'h3C);
    step(1, 0, 18'h00010, 8'h00);
    check("rd0_rv1", {31'b0, rv1}, 1);
    check("rd0_data", {24'b0, bus1}, 32'hA5);
    step(1, 0, 18'h00011, 8'h00);
    check("rd1_data", {24'b0, bus1}, 32'h3C);
    check("rd1_rc1", {14'b0, rc1}, 2);
    check("rd1_wc1", {14'b0, wc1}, 2);
    check("l3_not_emerged", {31'b0, rv3}, 0);
    step(1, 1, 18'h0, 8'h00);
    check("l3_ended_read", {31'b0, rv3}, 0);

    step(0, 1, 18'h01005, 8'h77);
    step(1, 0, 18'h00005, 8'h00);
    check("alias_data", {24'b0, bus1}, 32'h77);
    step(1, 1, 18'h0, 8'h00);

    step(0, 1, 18'h00020, 8'h11);
    step(1, 0, 18'h00020, 8'h00);
    step(1, 1, 18'h0, 8'h00);
    check("snap_idle_rv4", {31'b0, rv4}, 0);
    step(0, 1, 18'h00020, 8'h99);
    check("snap_wr_rv4", {31'b0, rv4}, 0);
    step(1, 0, 18'h00021, 8'h00);
    check("snap_rv4", {31'b0, rv4}, 1);
    check("snap_data4", {24'b0, bus4}, 32'h11);
    check("zero_init", {24'b0, bus1}, 32'h00);
    step(1, 0, 18'h00020, 8'h00);
    check("new_data1", {24'b0, bus1}, 32'h99);
    check("snap_after_rv4", {31'b0, rv4}, 0);
    step(1, 0, 18'h00020, 8'h00);
    step(1, 0, 18'h00020, 8'h00);
    check("b2b_rv3", {31'b0, rv3}, 1);
    check("b2b_data3", {24'b0, bus3}, 32'h99);
    step(1, 0, 18'h00020, 8'h00);
    check("new_data4", {24'b0, bus4}, 32'h99);
    check("rc_mid", {14'b0, rc4}, 9);

    step(1, 0, 18'h00011, 8'h00);
    step(0, 0, 18'h00011, 8'hEE);
    check("conf_err1", {31'b0, err1}, 1);
    check("conf_rv1", {31'b0, rv1}, 0);
    check("conf_wc3", {14'b0, wc3}, 5);
    check("conf_rc3", {14'b0, rc3}, 10);
    step(1, 0, 18'h00012, 8'h00);
    check("conf_killed_rv3", {31'b0, rv3}, 0);
    step(1, 0, 18'h00011, 8'h00);
    check("conf_mem_kept", {24'b0, bus1}, 32'h3C);
    check("conf_sticky", {31'b0, err3}, 1);

    step(1, 0, 18'h00030, 8'h00);
    step(0, 1, 18'h00030, 8'h5A);
    check("turn_rv1", {31'b0, rv1}, 0);
    step(1, 0, 18'h00030, 8'h00);
    check("turn_data", {24'b0, bus1}, 32'h5A);
    check("turn_wc1", {14'b0, wc1}, 6);
    check("turn_rc1", {14'b0, rc1}, 14);

    step(1, 0, 18'h00010, 8'h00);
    step(1, 0, 18'h00011, 8'h00);
    check("pre_rst_rv1", {31'b0, rv1}, 1);
    rst = 1'b1;
    #1;
    check("arst_rv3", {31'b0, rv3}, 0);
    check("arst_rv1", {31'b0, rv1}, 0);
    check("arst_wc3", {14'b0, wc3}, 0);
    check("arst_rc3", {14'b0, rc3}, 0);
    check("arst_err3", {31'b0, err3}, 0);
    step(1, 0, 18'h00010, 8'h00);
    check("rst_hold_rc3", {14'b0, rc3}, 0);
    rst = 1'b0;
    #1;
    check("rel_rv3", {31'b0, rv3}, 0);
    step(1, 0, 18'h00010, 8'h00);
    check("first_edge_rc3", {14'b0, rc3}, 1);
    check("first_edge_rv3", {31'b0, rv3}, 0);
    step(1, 0, 18'h00010, 8'h00);
    check("refill_rv3", {31'b0, rv3}, 0);
    step(1, 0, 18'h00010, 8'h00);
    check("refill_rv3_on", {31'b0, rv3}, 1);
    check("refill_data3", {24'b0, bus3}, 32'hA5);
    check("refill_rc3", {14'b0, rc3}, 3);

    step(1, 1, 18'h0, 8'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
